cbus_sram_responder: RTL and testbench

CBUS_SRAM_RESPONDER -- requirements
Module: cbus_sram_responder

---
 rtl/cbus_sram_responder_pkg.sv | 56 +++++
 rtl/cbus_burst_addr.sv | 38 +++
 rtl/cbus_sram_responder.sv | 163 ++++++++++++++++
 tb/tb_cbus_sram_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_sram_responder_pkg
// Description : Shared CBUS types (request/response, burst and len encoding)
//               plus the responder FSM state enum and default latency.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_sram_responder_pkg;

    localparam int c_cbus_addr_w          = 32;
    localparam int c_cbus_data_w          = 64;
    localparam int c_cbus_strb_w          = 8;
    localparam int c_cbus_len_w           = 8;
    localparam int c_cbus_default_latency = 2;

    // Burst addressing modes
    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } cbus_burst_e;

    // Initiator request; len encodes (beats - 1)
    typedef struct packed {
        logic                     valid;
        logic                     is_write;
        logic [2:0]               size;
        logic [c_cbus_addr_w-1:0] addr;
        logic [c_cbus_strb_w-1:0] strobe;
        logic [c_cbus_data_w-1:0] data;
        logic [c_cbus_len_w-1:0]  len;
        cbus_burst_e              burst;
    } cbus_req_t;

    // Responder reply
    typedef struct packed {
        logic                     ready;
        logic                     last;
        logic [c_cbus_data_w-1:0] data;
    } cbus_resp_t;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } cbus_state_e;

    // Number of beats carried by a len field
    function automatic int unsigned cbus_beats(input logic [c_cbus_len_w-1:0] len);
        return int'(len) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cbus_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : cbus_burst_addr
// Description : Computes the memory word addressed by a given beat of a
//               FIXED / INCR / WRAP burst. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_burst_addr
    import cbus_sram_responder_pkg::*;
#(
    parameter int WORD_W = 12
) (
    input  logic [WORD_W-1:0]       start_word,
    input  logic [c_cbus_len_w-1:0] len,
    input  cbus_burst_e             burst,
    input  logic [c_cbus_len_w-1:0] beat,
    output logic [WORD_W-1:0]       beat_word
);

    logic [WORD_W-1:0] w_len_mask;
    logic [WORD_W-1:0] w_incr_word;

    // INCR address wraps naturally modulo the memory depth; WRAP keeps the
    // upper bits of the start word and wraps the low bits selected by len
    // (len+1 is a power of two, so len itself is the in-block mask).
    always_comb begin
        w_len_mask  = WORD_W'(len);
        w_incr_word = start_word + WORD_W'(beat);
        case (burst)
            BURST_FIXED: beat_word = start_word;
            BURST_INCR:  beat_word = w_incr_word;
            BURST_WRAP:  beat_word = (start_word & ~w_len_mask) | (w_incr_word & w_len_mask);
            default:     beat_word = start_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : cbus_sram_responder
// Description : CBUS responder backed by a 64-bit word register array.
//               Accepts one burst at a time, waits LATENCY cycles, then
//               streams len+1 beats with byte-strobed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_sram_responder
    import cbus_sram_responder_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = c_cbus_default_latency
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int c_word_w = $clog2(DEPTH);

    cbus_state_e              r_state;
    cbus_state_e              w_state_nxt;
    logic [c_word_w-1:0]      r_start_word;
    logic [c_cbus_len_w-1:0]  r_len;
    cbus_burst_e              r_burst;
    logic                     r_is_write;
    logic [3:0]               r_lat_cnt;
    logic [c_cbus_len_w-1:0]  r_beat_cnt;

    logic                     w_beat;
    logic                     w_last;
    logic [c_word_w-1:0]      w_beat_word;
    logic [c_cbus_strb_w-1:0] w_byte_we;
    logic                     w_unused_bits;

    logic [c_cbus_data_w-1:0] r_mem [DEPTH];

    // Size never affects addressing, and address bits outside the word index
    // are ignored so accesses alias modulo DEPTH.
    assign w_unused_bits = &{1'b0, creq.size, creq.addr[2:0],
                             creq.addr[c_cbus_addr_w-1:c_word_w+3]};

    cbus_burst_addr #(
        .WORD_W (c_word_w)
    ) u_burst_addr (
        .start_word (r_start_word),
        .len        (r_len),
        .burst      (r_burst),
        .beat       (r_beat_cnt),
        .beat_word  (w_beat_word)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and response outputs; dropping valid mid-transaction aborts
    // without issuing a beat in that cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (creq.valid) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!creq.valid) begin
                    w_state_nxt = IDLE;
                end else if (r_lat_cnt == 4'd0) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (!creq.valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_beat = 1'b1;
                    w_last = (r_beat_cnt == r_len);
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        cresp       = '0;
        cresp.ready = w_beat;
        cresp.last  = w_last;
        if (w_beat && !r_is_write) begin
            cresp.data = r_mem[w_beat_word];
        end
    end

    // Transaction capture, latency countdown and beat counting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_word <= '0;
            r_len        <= '0;
            r_burst      <= BURST_FIXED;
            r_is_write   <= 1'b0;
            r_lat_cnt    <= 4'd0;
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (creq.valid) begin
                        r_start_word <= creq.addr[3 +: c_word_w];
                        r_len        <= creq.len;
                        r_burst      <= creq.burst;
                        r_is_write   <= creq.is_write;
                        r_lat_cnt    <= 4'(LATENCY - 1);
                        r_beat_cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (r_lat_cnt != 4'd0) begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                BURST: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Byte enables only during an accepted write beat; reset forces IDLE
    // asynchronously, so no partial beat can commit after it asserts.
    always_comb begin
        w_byte_we = (w_beat && r_is_write) ? creq.strobe : '0;
    end

    // Memory array, deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < c_cbus_strb_w; i++) begin
            if (w_byte_we[i]) begin
                r_mem[w_beat_word][8*i +: 8] <= creq.data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_sram_responder
// Description : Table-driven directed bench for cbus_sram_responder with
//               hand-written sequences for abort and back-to-back cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_sram_responder;
    import cbus_sram_responder_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4096;

    logic       clk;
    logic       reset;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    int checks;
    int failures;

    cbus_sram_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit               wr;
        logic [31:0]      addr;
        logic [7:0]       len;
        cbus_burst_e      burst;
        logic [7:0]       strb;
        logic [3:0][63:0] d;        // write data per beat, or expected read data
        int               rst_beat; // beat during which reset is asserted, -1 = none
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [7:0] len, cbus_burst_e b,
                                logic [7:0] strb, logic [63:0] d0, logic [63:0] d1,
                                logic [63:0] d2, logic [63:0] d3, int rb);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.burst = b; v.strb = strb;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.rst_beat = rb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one transaction starting at posedge+1 with the FSM in IDLE.
    task automatic run_xfer(input vec_t v);
        int beat;
        int first;
        int n_exp;
        bit done;
        bit saw;
        beat  = 0;
        first = -1;
        done  = 1'b0;
        n_exp = (v.rst_beat >= 0) ? v.rst_beat : int'(v.len) + 1;
        creq.valid    = 1'b1;
        creq.is_write = v.wr;
        creq.size     = 3'd3;
        creq.addr     = v.addr;
        creq.len      = v.len;
        creq.burst    = v.burst;
        creq.strobe   = v.strb;
        creq.data     = v.wr ? v.d[0] : 64'h0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            saw = cresp.ready;
            if (saw) begin
                if (beat == 0) first = cyc;
                if (beat == v.rst_beat) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_ready", cresp.ready, 0);
                    chk("rst_last", cresp.last, 0);
                    chk("rst_data", cresp.data, 0);
                    done = 1'b1;
                end else begin
                    chk("last", cresp.last, (beat == int'(v.len)) ? 1 : 0);
                    if (!v.wr && beat < 4) chk("rdata", cresp.data, v.d[beat]);
                    beat++;
                    if (cresp.last || beat > int'(v.len)) done = 1'b1;
                end
            end else begin
                chk("idle_last", cresp.last, 0);
                chk("idle_data", cresp.data, 0);
            end
            @(posedge clk);
            #1;
            if (done) creq.valid = 1'b0;
            else if (saw && v.wr && beat < 4) creq.data = v.d[beat];
        end
        creq.valid = 1'b0;
        chk("first_beat_cycle", 64'(first), 64'(LAT + 1));
        chk("beat_count", 64'(beat), 64'(n_exp));
        if (v.rst_beat >= 0) begin
            reset = 1'b0;
        end else begin
            @(negedge clk);
            chk("done_ready", cresp.ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int      nlast;
        bit      sw;
        bit      fin;
        int      nready;
        int      rcyc[$];
        logic [63:0] rdat[$];
        checks   = 0;
        failures = 0;

        vecs[0]  = mk(1, 32'h28,   0, BURST_INCR,  8'hFF, 64'h1122334455667788, 0, 0, 0, -1);
        vecs[1]  = mk(0, 32'h28,   0, BURST_INCR,  8'hFF, 64'h1122334455667788, 0, 0, 0, -1);
        vecs[2]  = mk(1, 32'h100,  3, BURST_INCR,  8'hFF, 64'hA0, 64'hA1, 64'hA2, 64'hA3, -1);
        vecs[3]  = mk(0, 32'h100,  3, BURST_INCR,  8'hFF, 64'hA0, 64'hA1, 64'hA2, 64'hA3, -1);
        vecs[4]  = mk(1, 32'h300,  0, BURST_INCR,  8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, -1);
        vecs[5]  = mk(1, 32'h300,  0, BURST_INCR,  8'h0F, 64'h0, 0, 0, 0, -1);
        vecs[6]  = mk(0, 32'h300,  0, BURST_INCR,  8'hFF, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, -1);
        vecs[7]  = mk(1, 32'h0,    3, BURST_INCR,  8'hFF, 64'd0, 64'd1, 64'd2, 64'd3, -1);
        vecs[8]  = mk(0, 32'h18,   3, BURST_WRAP,  8'hFF, 64'd3, 64'd0, 64'd1, 64'd2, -1);
        vecs[9]  = mk(0, 32'h18,   3, BURST_FIXED, 8'hFF, 64'd3, 64'd3, 64'd3, 64'd3, -1);
        vecs[10] = mk(0, 32'h8028, 0, BURST_INCR,  8'hFF, 64'h1122334455667788, 0, 0, 0, -1);
        vecs[11] = mk(1, 32'h7FF8, 1, BURST_INCR,  8'hFF, 64'hD0, 64'hD1, 0, 0, -1);
        vecs[12] = mk(0, 32'h7FF8, 1, BURST_INCR,  8'hFF, 64'hD0, 64'hD1, 0, 0, -1);
        vecs[13] = mk(0, 32'h8,    1, BURST_WRAP,  8'hFF, 64'd1, 64'hD1, 0, 0, -1);
        vecs[14] = mk(1, 32'h200,  3, BURST_INCR,  8'hFF, 64'hCC0, 64'hCC1, 64'hCC2, 64'hCC3, -1);
        vecs[15] = mk(1, 32'h200,  3, BURST_INCR,  8'hFF, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 2);
        vecs[16] = mk(0, 32'h200,  3, BURST_INCR,  8'hFF, 64'hB0, 64'hB1, 64'hCC2, 64'hCC3, -1);

        // Reset state, with a request pending that must be ignored
        creq  = '0;
        reset = 1'b1;
        creq.valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_ready", cresp.ready, 0);
            chk("reset_last", cresp.last, 0);
            chk("reset_data", cresp.data, 0);
        end
        creq.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_xfer(vecs[i]);
        end

        // Abort in WAIT: valid for one cycle only, no beat may follow
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h28;
        creq.len = 8'd0; creq.burst = BURST_INCR;
        @(posedge clk);
        #1;
        creq.valid = 1'b0;
        nready = 0;
        repeat (6) begin
            @(negedge clk);
            if (cresp.ready) nready++;
        end
        chk("abort_wait_ready", 64'(nready), 0);
        @(posedge clk);
        #1;
        run_xfer(vecs[1]);

        // Back-to-back: valid held high across two reads
        nlast = 0; sw = 1'b0; fin = 1'b0;
        creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h100;
        creq.len = 8'd1; creq.burst = BURST_INCR;
        for (int cyc = 0; cyc < 30 && !fin; cyc++) begin
            @(negedge clk);
            if (cresp.ready) begin
                rcyc.push_back(cyc);
                rdat.push_back(cresp.data);
                if (cresp.last) nlast++;
            end
            @(posedge clk);
            #1;
            if (nlast == 1 && !sw) begin
                creq.addr = 32'h28;
                creq.len  = 8'd0;
                sw = 1'b1;
            end
            if (nlast == 2) begin
                creq.valid = 1'b0;
                fin = 1'b1;
            end
        end
        creq.valid = 1'b0;
        chk("b2b_beats", 64'(rcyc.size()), 3);
        if (rcyc.size() == 3) begin
            chk("b2b_first", 64'(rcyc[0]), 64'(LAT + 1));
            chk("b2b_gap", 64'(rcyc[2] - rcyc[1]), 64'(LAT + 3));
            chk("b2b_d0", rdat[0], 64'hA0);
            chk("b2b_d1", rdat[1], 64'hA1);
            chk("b2b_d2", rdat[2], 64'h1122334455667788);
        end
        @(negedge clk);
        chk("b2b_done_ready", cresp.ready, 0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
